// File: rtl/paddle_pkg.sv
// Shared types and helpers for the paddle update engine: FSM states, the
// {x, y} position record and the saturating Y step.
package paddle_pkg;

  localparam int DEF_SCREEN_HEIGHT = 480;
  localparam int DEF_PADDLE_HEIGHT = 100;
  localparam int Y_MAX             = DEF_SCREEN_HEIGHT - DEF_PADDLE_HEIGHT;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    WRITE
  } paddle_state_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } paddle_pos_t;

  // Signed 17-bit so an upward step below zero clamps instead of wrapping.
  function automatic logic [15:0] sat_step(
    input logic [15:0] y,
    input logic [15:0] step,
    input logic        up,
    input logic        dn,
    input logic [15:0] y_max = 16'(Y_MAX)
  );
    logic signed [16:0] t;
    t = $signed({1'b0, y});
    if (up && !dn) begin
      t = t - $signed({1'b0, step});
      if (t < 0) t = '0;
    end else if (dn && !up) begin
      t = t + $signed({1'b0, step});
      if (t > $signed({1'b0, y_max})) t = $signed({1'b0, y_max});
    end
    return t[15:0];
  endfunction

endpackage

// File: rtl/paddle_update_engine_rr_arbiter.sv
// Combinational round-robin pick: first requesting channel at or after ptr,
// wrapping modulo NUM_CH.
module rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic              gnt_valid
);

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (!gnt_valid && req[j]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/paddle_update_engine.sv
// Multi-player paddle Y engine: captures controller words, applies saturating
// moves round-robin and writes {X, Y} to the frame DPRAM. PADDLE_ACCEL_EN adds step acceleration.
module paddle_update_engine
  import paddle_pkg::*;
#(
  parameter int                   NUM_CH        = 2,
  parameter int                   CMD_W         = 34,
  parameter int                   UP_BIT        = 5,
  parameter int                   DN_BIT        = 4,
  parameter int                   SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
  parameter int                   PADDLE_HEIGHT = DEF_PADDLE_HEIGHT,
  parameter int                   PADDLE_INC    = 5,
  parameter logic [NUM_CH*16-1:0] PADDLE_X      = {16'd609, 16'd15},
  parameter int                   SETTLE_CYCLES = 10,
  parameter int                   BASE_ADDR     = 0,
  parameter int                   ADDR_STRIDE   = 1
`ifdef PADDLE_ACCEL_EN
  ,
  parameter int                   ACCEL_HOLD    = 4,
  parameter int                   ACCEL_MAX     = 20
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       cmd_valid,
  input  logic [NUM_CH*CMD_W-1:0] cmd_data,
  output logic [NUM_CH*32-1:0]    paddle_pos,
  output logic                    wr_en,
  input  logic                    wr_ready,
  output logic [15:0]             wr_addr,
  output logic [31:0]             wr_data,
  output logic [NUM_CH-1:0]       overrun,
  output logic                    busy
);

  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int Y_TOP  = SCREEN_HEIGHT - PADDLE_HEIGHT;
  localparam int Y_INIT = Y_TOP / 2;

  paddle_state_t     state_q, state_d;
  logic [NUM_CH-1:0] pending_q, overrun_q, clr;
  logic [1:0]        cmd_reg [NUM_CH];   // {up, dn}: the only bits that move a paddle
  logic [15:0]       y_q [NUM_CH];
  paddle_pos_t       pos [NUM_CH];
  logic [IDX_W-1:0]  rr_ptr_q, gnt_q, gnt_idx;
  logic              gnt_valid, grant;
  logic [CNT_W-1:0]  cnt_q;
  logic [15:0]       step;
  logic              cmd_up, cmd_dn;
  logic              unused_cmd_bits;

  assign unused_cmd_bits = ^cmd_data;

  rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_arb (
    .req       (pending_q),
    .ptr       (rr_ptr_q),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign grant   = (state_q == IDLE) && gnt_valid;
  assign cmd_up  = cmd_reg[gnt_idx][1];
  assign cmd_dn  = cmd_reg[gnt_idx][0];
  assign busy    = (state_q != IDLE);
  assign overrun = overrun_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_pos
    assign pos[i].x = PADDLE_X[i*16 +: 16];
    assign pos[i].y = y_q[i];
    assign paddle_pos[i*32 +: 32] = pos[i];
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: defaults first so no path through this block leaves a signal unassigned (no latch).
  always_comb begin
    state_d = state_q;
    clr     = '0;
    if (grant) clr[gnt_idx] = 1'b1;
    case (state_q)
      IDLE:    if (grant) state_d = SETTLE;
      SETTLE:  if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) state_d = WRITE;
      WRITE:   if (wr_en && wr_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: cmd_reg is only read while its pending bit is set, so it carries no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++)
      if (cmd_valid[i])
        cmd_reg[i] <= {cmd_data[i*CMD_W + UP_BIT], cmd_data[i*CMD_W + DN_BIT]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      overrun_q <= '0;
      rr_ptr_q  <= '0;
      gnt_q     <= '0;
      cnt_q     <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= 16'(BASE_ADDR);
      wr_data   <= '0;
      for (int i = 0; i < NUM_CH; i++) y_q[i] <= 16'(Y_INIT);
    end else begin
      // A fresh word on the channel being granted stays pending without overrun.
      pending_q <= (pending_q & ~clr) | cmd_valid;
      overrun_q <= overrun_q | (cmd_valid & pending_q & ~clr);

      if (grant) begin
        y_q[gnt_idx] <= sat_step(y_q[gnt_idx], step, cmd_up, cmd_dn, 16'(Y_TOP));
        gnt_q        <= gnt_idx;
        rr_ptr_q     <= (gnt_idx == IDX_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
        cnt_q        <= '0;
      end else if (state_q == SETTLE) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (state_q == WRITE && !wr_en) begin
        wr_en   <= 1'b1;
        wr_addr <= 16'(BASE_ADDR + int'(gnt_q) * ADDR_STRIDE);
        wr_data <= pos[gnt_q];
      end else if (wr_en && wr_ready) begin
        wr_en <= 1'b0;
      end
    end
  end

`ifdef PADDLE_ACCEL_EN
  localparam int RUN_W = $clog2(ACCEL_HOLD + 2);

  logic [RUN_W-1:0]  run_q [NUM_CH];
  logic [15:0]       step_q [NUM_CH];
  logic [NUM_CH-1:0] last_up_q;
  logic [RUN_W-1:0]  run_d;
  logic [16:0]       dbl;

  // run_d counts consecutive same-direction moves, saturating just past ACCEL_HOLD.
  always_comb begin
    run_d = '0;
    step  = 16'(PADDLE_INC);
    dbl   = {step_q[gnt_idx], 1'b0};
    if (cmd_up ^ cmd_dn) begin
      if (run_q[gnt_idx] != '0 && last_up_q[gnt_idx] == cmd_up)
        run_d = (run_q[gnt_idx] == RUN_W'(ACCEL_HOLD + 1)) ? run_q[gnt_idx]
                                                            : run_q[gnt_idx] + 1'b1;
      else
        run_d = RUN_W'(1);
      if (run_d > RUN_W'(ACCEL_HOLD))
        step = (dbl > 17'(ACCEL_MAX)) ? 16'(ACCEL_MAX) : dbl[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_up_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        run_q[i]  <= '0;
        step_q[i] <= 16'(PADDLE_INC);
      end
    end else if (grant) begin
      run_q[gnt_idx]     <= run_d;
      step_q[gnt_idx]    <= step;
      last_up_q[gnt_idx] <= cmd_up;
    end
  end
`else
  assign step = 16'(PADDLE_INC);
`endif

endmodule

// File: tb/tb_paddle_update_engine.sv
// Scoreboard bench for paddle_update_engine: a reference model pushes the
// expected DPRAM writes, which are popped and compared as the DUT issues them.
module tb_paddle_update_engine;

  localparam int NUM_CH = 2;
  localparam int CMD_W  = 34;
  localparam int XPOS [2] = '{15, 609};

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_CH-1:0]       cmd_valid;
  logic [NUM_CH*CMD_W-1:0] cmd_data;
  logic [NUM_CH*32-1:0]    paddle_pos;
  logic                    wr_en;
  logic                    wr_ready;
  logic [15:0]             wr_addr;
  logic [31:0]             wr_data;
  logic [NUM_CH-1:0]       overrun;
  logic                    busy;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];
  int  checks   = 0;
  int  failures = 0;
  int  my [2];
  int  mrun [2];
  int  mstep [2];
  bit  mlast [2];

  paddle_update_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_data   (cmd_data),
    .paddle_pos (paddle_pos),
    .wr_en      (wr_en),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] y_of(input int ch);
    return paddle_pos[ch*32 +: 16];
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      my[c] = 190; mrun[c] = 0; mstep[c] = 5; mlast[c] = 1'b0;
    end
    sb.delete();
  endfunction

  // Reference behaviour for one serviced command; pushes the expected write.
  function automatic void model_apply(input int ch, input bit up, input bit dn);
    wr_t e;
    int  st;
    st = 5;
`ifdef PADDLE_ACCEL_EN
    if (up ^ dn) begin
      if (mrun[ch] > 0 && mlast[ch] == up) mrun[ch]++;
      else mrun[ch] = 1;
      if (mrun[ch] > 4) st = (mstep[ch] * 2 > 20) ? 20 : mstep[ch] * 2;
      mstep[ch] = st;
      mlast[ch] = up;
    end else begin
      mrun[ch]  = 0;
      mstep[ch] = 5;
    end
`endif
    if (up && !dn) my[ch] = (my[ch] - st < 0) ? 0 : my[ch] - st;
    if (dn && !up) my[ch] = (my[ch] + st > 380) ? 380 : my[ch] + st;
    e.addr = 16'(ch);
    e.data = {16'(XPOS[ch]), 16'(my[ch])};
    sb.push_back(e);
  endfunction

  // Called at a falling edge; holds the strobe for exactly one cycle.
  task automatic drive_cmd(input logic [1:0] mask, input logic [1:0] up, input logic [1:0] dn);
    cmd_valid = mask;
    cmd_data  = '0;
    for (int c = 0; c < 2; c++) begin
      cmd_data[c*CMD_W + 5] = up[c];
      cmd_data[c*CMD_W + 4] = dn[c];
    end
    @(negedge clk);
    cmd_valid = '0;
    cmd_data  = '0;
  endtask

  task automatic expect_write(input string name, input int stall);
    wr_t e;
    int  cyc;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard empty got_addr=%0d", name, wr_addr);
      return;
    end
    e = sb.pop_front();
    cyc = 0;
    while (wr_en !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    if (wr_en !== 1'b1) begin
      failures++;
      $display("FAIL %s_timeout wr_en=%b expected 1", name, wr_en);
      return;
    end
    for (int s = 0; s < stall; s++) begin
      checks++;
      if ({wr_en, wr_addr, wr_data} !== {1'b1, e.addr, e.data}) begin
        failures++;
        $display("FAIL %s_stable en=%b addr=%0d data=%h expected addr=%0d data=%h",
                 name, wr_en, wr_addr, wr_data, e.addr, e.data);
      end
      @(negedge clk);
    end
    wr_ready = 1'b1;
    checks++;
    if (wr_addr !== e.addr || wr_data !== e.data) begin
      failures++;
      $display("FAIL %s addr=%0d data=%h expected addr=%0d data=%h",
               name, wr_addr, wr_data, e.addr, e.data);
    end
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b0) begin
      failures++;
      $display("FAIL %s_complete wr_en=%b expected 0", name, wr_en);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (paddle_pos !== {16'd609, 16'd190, 16'd15, 16'd190} || wr_en !== 1'b0 ||
        wr_addr !== 16'd0 || wr_data !== 32'd0 || overrun !== 2'b00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s pos=%h en=%b addr=%0d data=%h ovr=%b busy=%b expected pos=%h all else 0",
               name, paddle_pos, wr_en, wr_addr, wr_data, overrun, busy,
               {16'd609, 16'd190, 16'd15, 16'd190});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_ready = 1'b1; cmd_valid = '0; cmd_data = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_single_dn();
    int cyc;
    model_apply(0, 1'b0, 1'b1);
    drive_cmd(2'b01, 2'b00, 2'b01);
    @(negedge clk);
    checks++;
    if (y_of(0) !== 16'd195 || busy !== 1'b1 || wr_en !== 1'b0) begin
      failures++;
      $display("FAIL grant_update y0=%0d busy=%b wr_en=%b expected 195 1 0", y_of(0), busy, wr_en);
    end
    cyc = 0;
    while (wr_en !== 1'b1 && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != 11) begin
      failures++;
      $display("FAIL grant_to_wr_en latency=%0d expected 11", cyc);
    end
    expect_write("single_dn", 0);
  endtask

  task automatic test_no_move();
    model_apply(0, 1'b1, 1'b1);
    drive_cmd(2'b01, 2'b01, 2'b01);
    expect_write("no_move", 0);
    checks++;
    if (y_of(0) !== 16'(my[0])) begin
      failures++;
      $display("FAIL no_move_y y0=%0d expected %0d", y_of(0), my[0]);
    end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 40; k++) begin
      model_apply(1, 1'b1, 1'b0);
      drive_cmd(2'b10, 2'b10, 2'b00);
      expect_write("sat_up", 0);
    end
    checks++;
    if (y_of(1) !== 16'd0) begin
      failures++;
      $display("FAIL sat_up_floor y1=%0d expected 0", y_of(1));
    end
    for (int k = 0; k < 40; k++) begin
      model_apply(0, 1'b0, 1'b1);
      drive_cmd(2'b01, 2'b00, 2'b01);
      expect_write("sat_dn", 0);
    end
    checks++;
    if (y_of(0) !== 16'd380) begin
      failures++;
      $display("FAIL sat_dn_ceiling y0=%0d expected 380", y_of(0));
    end
  endtask

  task automatic test_round_robin();
    // Last grant was ch0, so the pointer now favours ch1.
    model_apply(1, 1'b0, 1'b1);
    model_apply(0, 1'b1, 1'b0);
    drive_cmd(2'b11, 2'b01, 2'b10);
    expect_write("rr_first_ch1", 0);
    expect_write("rr_then_ch0", 0);
    model_apply(1, 1'b0, 1'b1);
    drive_cmd(2'b10, 2'b00, 2'b10);
    expect_write("rr_single_ch1", 0);
    model_apply(0, 1'b1, 1'b0);
    model_apply(1, 1'b0, 1'b1);
    drive_cmd(2'b11, 2'b01, 2'b10);
    expect_write("rr_first_ch0", 0);
    expect_write("rr_then_ch1", 0);
  endtask

  task automatic test_overrun();
    checks++;
    if (overrun !== 2'b00) begin
      failures++;
      $display("FAIL overrun_clear ovr=%b expected 00", overrun);
    end
    model_apply(1, 1'b0, 1'b1);
    drive_cmd(2'b10, 2'b00, 2'b10);
    drive_cmd(2'b01, 2'b01, 2'b00);
    drive_cmd(2'b01, 2'b00, 2'b01);
    model_apply(0, 1'b0, 1'b1);
    checks++;
    if (overrun !== 2'b01) begin
      failures++;
      $display("FAIL overrun_set ovr=%b expected 01", overrun);
    end
    expect_write("ovr_ch1", 0);
    expect_write("ovr_newest_ch0", 0);
  endtask

  task automatic test_grant_collision();
    model_apply(1, 1'b1, 1'b0);
    model_apply(1, 1'b0, 1'b1);
    drive_cmd(2'b10, 2'b10, 2'b00);
    drive_cmd(2'b10, 2'b00, 2'b10);
    expect_write("collide_a", 0);
    expect_write("collide_b", 0);
    checks++;
    if (overrun !== 2'b01) begin
      failures++;
      $display("FAIL collide_overrun ovr=%b expected 01", overrun);
    end
  endtask

  task automatic test_stall();
    wr_ready = 1'b0;
    model_apply(0, 1'b1, 1'b0);
    drive_cmd(2'b01, 2'b01, 2'b00);
    expect_write("stall", 7);
  endtask

  task automatic test_reset_mid();
    int cyc;
    checks++;
    if (overrun !== 2'b01) begin
      failures++;
      $display("FAIL overrun_sticky ovr=%b expected 01", overrun);
    end
    drive_cmd(2'b01, 2'b01, 2'b00);
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL settle_busy busy=%b expected 1", busy);
    end
    #2 rst_n = 1'b0;
    #1 check_reset_values("reset_in_settle");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    wr_ready = 1'b0;
    drive_cmd(2'b10, 2'b00, 2'b10);
    cyc = 0;
    while (wr_en !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (wr_en !== 1'b1) begin
      failures++;
      $display("FAIL reset_write_reach wr_en=%b expected 1", wr_en);
    end
    #2 rst_n = 1'b0;
    #1 check_reset_values("reset_in_write");
    @(negedge clk);
    rst_n = 1'b1;
    wr_ready = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

`ifdef PADDLE_ACCEL_EN
  task automatic test_accel();
    int exp_steps [7] = '{5, 5, 5, 5, 10, 20, 20};
    int prev;
    prev = 190;
    for (int k = 0; k < 7; k++) begin
      model_apply(0, 1'b0, 1'b1);
      drive_cmd(2'b01, 2'b00, 2'b01);
      expect_write("accel", 0);
      prev = prev + exp_steps[k];
      checks++;
      if (y_of(0) !== 16'(prev)) begin
        failures++;
        $display("FAIL accel_step%0d y0=%0d expected %0d", k, y_of(0), prev);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_dn();
    test_no_move();
    test_saturate();
    test_round_robin();
    test_overrun();
    test_grant_collision();
    test_stall();
    test_reset_mid();
`ifdef PADDLE_ACCEL_EN
    test_accel();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
